// File: rtl/ser_to_par6_pkg.sv
// rtl/ser_to_par6_pkg.sv - shared types and widths for ser_to_par6 (PARITY_CHECK_EN adds the PARITY state)
package ser_to_par6_pkg;

  localparam int DATA_W = 6;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA
`ifdef PARITY_CHECK_EN
    ,
    ST_PARITY
`endif
  } state_t;

endpackage

// File: rtl/ser_to_par6_shreg.sv
// rtl/ser_to_par6_shreg.sv - 6-bit shift register; MSB_FIRST=1 moves the first bit toward data[5]
module ser_to_par6_shreg
  import ser_to_par6_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST != 0) begin
        data <= {data[DATA_W-2:0], bit_in};
      end else begin
        data <= {bit_in, data[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/ser_to_par6.sv
// rtl/ser_to_par6.sv - framed serial-to-6-bit-parallel deserializer
// Define PARITY_CHECK_EN to expect and check a trailing even-parity bit.
module ser_to_par6
  import ser_to_par6_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ser_in,
  input  logic              ser_en,
  output logic [DATA_W-1:0] par_out,
  output logic              par_valid,
  output logic              busy,
  output logic              parity_err
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               frame_done;
  logic               shift_en;
  logic [DATA_W-1:0]  shreg_q;
`ifdef PARITY_CHECK_EN
  logic               par_bit;
`endif

  assign shift_en = ser_en && (state == ST_DATA);

  ser_to_par6_shreg #(
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .shift_en(shift_en),
    .bit_in  (ser_in),
    .data    (shreg_q)
  );

  // frame_done marks the final-bit edge; the word is published one edge later.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      par_out    <= '0;
      par_valid  <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      par_valid  <= frame_done;
      if (frame_done) begin
        par_out <= shreg_q;
`ifdef PARITY_CHECK_EN
        parity_err <= (^shreg_q) ^ par_bit;
`endif
      end
      if (ser_en) begin
        case (state)
          ST_IDLE: begin
            if (ser_in) begin
              state <= ST_DATA;
              busy  <= 1'b1;
              cnt   <= '0;
            end
          end
          ST_DATA: begin
            if (cnt == CNT_W'(DATA_W - 1)) begin
              cnt <= '0;
`ifdef PARITY_CHECK_EN
              state <= ST_PARITY;
`else
              state      <= ST_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef PARITY_CHECK_EN
          ST_PARITY: begin
            par_bit    <= ser_in;
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
`endif
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef PARITY_CHECK_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/ser_to_par6.md
SER_TO_PAR6 -- requirements
Module: ser_to_par6

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = first data bit lands in par_out[5] and 0 = first data bit lands in par_out[0].
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_in, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port ser_in, input, 1 bit: serial line; idles at 0.
REQ-005 The block SHALL have port ser_en, input, 1 bit: sample strobe; ser_in is sampled only in cycles where ser_en=1.
REQ-006 The block SHALL have port par_out, output, 6 bits: registered, assembled data word.
REQ-007 The block SHALL have port par_valid, output, 1 bit: single-cycle pulse marking a new par_out.
REQ-008 The block SHALL have port busy, output, 1 bit: 1 while a frame is in progress.
REQ-009 The block SHALL have port parity_err, output, 1 bit: parity mismatch flag, qualified by par_valid.

Function
REQ-010 The frame format SHALL be a start bit (1), then 6 data bits, then one even-parity bit when PARITY_CHECK_EN is defined.
REQ-011 The FSM SHALL have states IDLE, DATA and PARITY; PARITY exists only with the macro.
REQ-012 IDLE SHALL go to DATA on a sample with ser_in=1; an IDLE sample with ser_in=0 SHALL be ignored.
REQ-013 DATA SHALL shift in one bit per sample using a 3-bit counter running 0..5.
REQ-014 After the 6th data sample, the FSM SHALL go to PARITY when the macro is defined, and otherwise to IDLE.
REQ-015 PARITY SHALL go to IDLE on its sample.
REQ-016 Latency: par_out SHALL update and par_valid SHALL pulse high exactly one clk_in cycle after the edge that samples the final frame bit (the 6th data bit, or the parity bit with the macro).
REQ-017 par_out SHALL hold its value until the next completed frame, and par_valid SHALL be low in all other cycles.
REQ-018 busy SHALL be 1 in DATA and PARITY and 0 in IDLE.
REQ-019 When ser_en=0 mid-frame, the state, counter and shift register SHALL hold with no timeout.
REQ-020 A start bit sampled in the same cycle that par_valid is high SHALL be accepted, so back-to-back frames need no gap.
REQ-021 A word SHALL be delivered even when parity_err=1.

Reset
REQ-022 Asserting rst_in SHALL immediately force the FSM to IDLE, the counter to 0, the shift register to 0, par_out to 6'b000000, and par_valid, busy and parity_err to 0.
REQ-023 A reset mid-frame SHALL discard the partial word without a par_valid pulse.
REQ-024 The first sample after rst_in deasserts SHALL be treated as an IDLE sample.

Configuration
REQ-025 Macro PARITY_CHECK_EN SHALL control parity checking.
REQ-026 With PARITY_CHECK_EN defined, the block SHALL expect a parity bit and set parity_err = (XOR of the 6 data bits) XOR (parity bit), registered alongside par_valid.
REQ-027 Without PARITY_CHECK_EN, there SHALL be no PARITY state and no parity bit, and parity_err SHALL be tied to 0.

Structure
REQ-028 Package ser_to_par6_pkg SHALL hold the FSM state enum and constants DATA_W=6 and CNT_W=3.
REQ-029 One sub-module, ser_to_par6_shreg, SHALL implement the 6-bit shift register with load-enable and MSB_FIRST direction; the FSM, counter and outputs SHALL stay in the top level.

Verification
REQ-030 Reset mid-frame: rst_in pulses after 3 data bits -> busy=0, par_out=000000, no par_valid; the next full frame decodes correctly.
REQ-031 Basic frame (macro off, MSB_FIRST=1, ser_en=1 constant): send 1,1,0,1,0,1,1 -> par_out=6'b101011 and one par_valid pulse one cycle after the 7th sample; busy high for exactly 6 cycles.
REQ-032 Gapped strobe: same frame with ser_en toggling 1,0,1,0... -> same par_out=101011; busy holds across the gaps.
REQ-033 Parity (macro on): frame 101011 with parity 0 -> parity_err=0; the same frame with parity 1 -> parity_err=1, par_out=101011, par_valid pulses in both cases.
REQ-034 Back-to-back: a second start bit sampled in the par_valid cycle, then data 000001 -> second par_valid exactly 7 samples later with par_out=000001 (MSB_FIRST=0 variant: 100000).
